// File: rtl/rapid_pkg.sv
// Shared types and constants for the fetch front end.
package rapid_pkg;

  localparam int unsigned IF_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [IF_XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ,
    IF_WAIT,
    IF_DRAIN,
    IF_FAULT
  } IF_state_t;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instruction;
  } fetch_entry_s;

  // Head value presented after reset or flush
  localparam fetch_entry_s EMPTY_ENTRY = '{pc: '0, instruction: RV_NOP};

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two depth FIFO of {pc, instruction} with a registered head.
module fetch_fifo
  import rapid_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  fetch_entry_s     i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output fetch_entry_s     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_s     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  fetch_entry_s     head_q;
  fetch_entry_s     head_d;
  logic             pop_ok;

  assign pop_ok  = i_pop && (count_q != '0);
  assign o_head  = head_q;
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));

  // Next count and next head; a push into the slot about to be read bypasses storage
  always_comb begin
    rd_next = rd_ptr + PTR_W'(pop_ok);
    count_d = count_q + CNT_W'(i_push) - CNT_W'(pop_ok);
    head_d  = head_q;
    if (count_d != '0) begin
      head_d = (i_push && (wr_ptr == rd_next)) ? i_data : mem[rd_next];
    end
  end

  // Storage write; entries need no reset since the count guards every read
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && i_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers, count and head register; flush overrides any push or pop
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= EMPTY_ENTRY;
    end else begin
      if (i_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= rd_next;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, one outstanding imem request, FIFO to decoder.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch
  import rapid_pkg::*;
#(
  parameter int unsigned      XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  input  logic            i_decoder_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instruction,
  output logic            o_fetch_fault
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  IF_state_t        state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             imem_req_c;
  logic             push;
  logic             flush;
  logic             misaligned;
  fetch_entry_s     push_entry;
  fetch_entry_s     fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned    = |i_redirect_pc[1:0];
  assign o_fetch_fault = (state_q == IF_FAULT);
`else
  assign misaligned    = 1'b0;
  assign o_fetch_fault = 1'b0;
`endif

  // Next-state, fetch PC and FIFO control; redirect overrides the per-state action
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    imem_req_c = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      IF_REQ: begin
        imem_req_c = !i_reset && (fifo_count < CNT_W'(FIFO_DEPTH)) && !i_redirect;
        if (imem_req_c && i_imem_ack) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (i_imem_rvalid) begin
          push    = 1'b1;
          state_d = IF_REQ;
        end
      end
      IF_DRAIN: begin
        if (i_imem_rvalid) begin
          state_d = IF_REQ;
        end
      end
      IF_FAULT: begin
        state_d = IF_FAULT;
      end
      default: state_d = IF_REQ;
    endcase

    if (i_redirect && (state_q != IF_FAULT)) begin
      flush = 1'b1;
      push  = 1'b0;
      if (misaligned) begin
        state_d = IF_FAULT;
      end else begin
        fetch_pc_d = i_redirect_pc & ~XLEN'(3);
        // A response still owed by memory must be swallowed before the next request
        state_d = ((state_q != IF_REQ) && !i_imem_rvalid) ? IF_DRAIN : IF_REQ;
      end
    end
  end

  // State, fetch PC and request PC registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IF_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Space is reserved at request time, so a push can only meet a full FIFO alongside a pop
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(push && fifo_full && !i_decoder_ready));
    end
  end

  assign push_entry.pc          = IF_XLEN'(req_pc_q);
  assign push_entry.instruction = IF_XLEN'(i_imem_rdata);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (push_entry),
    .i_pop   (i_decoder_ready),
    .i_flush (flush),
    .o_head  (fifo_head),
    .o_count (fifo_count),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_imem_req    = imem_req_c;
  assign o_imem_addr   = fetch_pc_q;
  assign o_valid       = !fifo_empty;
  assign o_pc          = XLEN'(fifo_head.pc);
  assign o_instruction = XLEN'(fifo_head.instruction);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of `instruction_decoder`. It owns the fetch PC, issues word requests to instruction memory over a req/ack + rvalid interface, and buffers returned `{pc, instruction}` pairs in a small FIFO. The FIFO is presented to the decoder with a valid/ready handshake. A redirect from execute (branch or jump) flushes the FIFO, discards any in-flight response, and restarts fetch at the target address.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `FIFO_DEPTH`, 2: entries in the fetch buffer; must be a power of two and at least 2.

Ports:
- `i_clk` input 1: clock; all state changes on its rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `o_imem_req` output 1: fetch request valid.
- `o_imem_addr` output XLEN: word address of the request.
- `i_imem_ack` input 1: memory accepted the request this cycle.
- `i_imem_rvalid` input 1: response data valid.
- `i_imem_rdata` input XLEN: fetched instruction word.
- `i_redirect` input 1: flush and restart fetch.
- `i_redirect_pc` input XLEN: restart address.
- `o_valid` output 1: FIFO head is valid for the decoder.
- `i_decoder_ready` input 1: decoder consumes the head this cycle (maps to the decoder's `i_pipeline_ready`).
- `o_pc` output XLEN: PC of the head entry.
- `o_instruction` output XLEN: head instruction.
- `o_fetch_fault` output 1: misaligned redirect detected. Only driven when `FETCH_ALIGN_CHECK_EN` is defined; tied 0 otherwise.

## Operation
- **States** (`IF_state_t`): `IF_REQ`, `IF_WAIT`, `IF_DRAIN`, `IF_FAULT`. Reset enters `IF_REQ`.
- **Reset values:**
  - `o_imem_req`=0, `o_valid`=0, `o_pc`=0, `o_instruction`=`RV_NOP` (32'h0000_0013), `o_fetch_fault`=0.
  - Fetch PC = `RESET_PC`, FIFO empty.
- **At most one request outstanding.**
- **`IF_REQ`:**
  - `o_imem_req = (fifo_count < FIFO_DEPTH) && !i_redirect`.
  - `o_imem_addr` = fetch PC.
  - Request and address are held stable until `i_imem_ack`.
  - On ack: latch the request PC, fetch PC += 4 (wraps modulo 2^XLEN), go to `IF_WAIT`.
- **`IF_WAIT`:** on `i_imem_rvalid`, push `{req_pc, i_imem_rdata}` and go to `IF_REQ`. Space for the push was reserved at request time, so a push never overflows.
- **Redirect** has the highest priority in every state except `IF_FAULT`:
  - FIFO is flushed.
  - Fetch PC is loaded with `i_redirect_pc`.
  - From `IF_WAIT` without rvalid in the same cycle: go to `IF_DRAIN`.
  - From `IF_WAIT` with rvalid in the same cycle: the response is dropped; go to `IF_REQ`.
  - From `IF_REQ`: stay in `IF_REQ`.
- **`IF_DRAIN`:** `o_imem_req`=0. The next rvalid is discarded, then go to `IF_REQ`. A redirect while in `IF_DRAIN` updates the fetch PC and stays in `IF_DRAIN`.
- **Decoder side:**
  - `o_valid` = FIFO not empty.
  - Pop on `o_valid && i_decoder_ready`.
  - When empty, `o_pc`/`o_instruction` hold the last popped values (`RV_NOP`/0 after reset or flush).
  - Push and pop in the same cycle leave the count unchanged.
  - A flush overrides a simultaneous push and pop.
- **Arithmetic:** the PC increment is unsigned XLEN-bit. Bits [1:0] of the fetch PC are always 0 when issued.

## Timing
- **Reset release:** `o_imem_req`=1 in the first cycle after `i_reset` falls.
- **Fetch latency:** with ack in cycle N and rvalid in N+1, the entry is visible (`o_valid`=1) in N+2. The FIFO output is registered; there is no bypass.
- **Redirect in cycle N:**
  - `o_valid`=0 from N+1.
  - Request to `i_redirect_pc` in N+1 if not draining; otherwise in the cycle after the stale rvalid.
- **Throughput:** one instruction per two cycles with a single-cycle memory. The FIFO absorbs decoder stalls.
- **Reset mid-operation:** wins over everything. An in-flight response arriving after reset is ignored because reset enters `IF_REQ` with no request outstanding and the response is not latched.

## Configuration
- **`FETCH_ALIGN_CHECK_EN` defined:**
  - A redirect with `i_redirect_pc[1:0]` != 0 flushes, sets `o_fetch_fault`=1 the next cycle, and enters `IF_FAULT`.
  - In `IF_FAULT`: no requests; further redirects are ignored; only reset exits.
  - `o_fetch_fault` is sticky until reset.
- **Not defined:** `i_redirect_pc[1:0]` is forced to 0, `o_fetch_fault` is tied 0, and `IF_FAULT` is unreachable.

## Structure
- **In `rapid_pkg`:**
  - `IF_state_t` enum.
  - `fetch_entry_s` struct (`pc`, `instruction`).
  - `RV_NOP` constant.
- **Sub-module `fetch_fifo`:** parameterised depth, stores `fetch_entry_s`, and provides push, pop, flush, count, and empty/full.

## Test plan
- **Reset, single-cycle memory returning 0x00A00093 at addr 0:** `o_imem_addr`=0, then 4. `o_valid`=1 with `o_pc`=0 and `o_instruction`=0x00A00093 two cycles after ack.
- **Decoder ready held low:** FIFO fills to `FIFO_DEPTH`=2 (pcs 0, 4) and `o_imem_req` drops. Raising ready pops pc 0 then pc 4, and requests resume at 8.
- **Redirect to 0x100 while in `IF_WAIT`, rvalid two cycles later:** the stale word is never presented, the next `o_imem_addr`=0x100, and the first `o_pc`=0x100.
- **Redirect and rvalid in the same cycle:** the response is dropped and the next request is issued to the redirect PC the following cycle.
- **`FETCH_ALIGN_CHECK_EN` defined, redirect to 0x102:** `o_fetch_fault`=1 next cycle and no further requests until reset. Without the macro, fetch resumes at 0x100.
- **Fetch PC at 0xFFFF_FFFC:** the next request address wraps to 0x0000_0000.
